// File: rtl/galois_lfsr_stream.sv
// Galois LFSR pattern generator with a valid/ready beat output, seed load and lock-up recovery.
// Optional runtime polynomial load: define GALOIS_LFSR_RUNTIME_POLY_EN.
module galois_lfsr_stream #(
    parameter int unsigned               LFSR_WIDTH = 8,
    parameter logic [LFSR_WIDTH-1:0]     LFSR_POLY  = LFSR_WIDTH'(8'h1D),
    parameter logic [LFSR_WIDTH-1:0]     LFSR_SEED  = LFSR_WIDTH'(1),
    parameter int unsigned               OUT_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] seed_in,
    input  logic [LFSR_WIDTH-1:0] poly_in,
    output logic [OUT_BITS-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  lockup_err,
    output logic [LFSR_WIDTH-1:0] state_o
);

    typedef enum logic [0:0] {StEmpty, StFull} fsm_e;

    fsm_e                  r_fsm;
    logic [LFSR_WIDTH-1:0] r_state;
    logic [OUT_BITS-1:0]   r_data;
    logic                  r_valid;
    logic                  r_lockup;

    logic [LFSR_WIDTH-1:0] w_poly;
    logic [LFSR_WIDTH-1:0] w_next;
    logic [OUT_BITS-1:0]   w_word;
    logic                  w_gen;

`ifdef GALOIS_LFSR_RUNTIME_POLY_EN
    logic [LFSR_WIDTH-1:0] r_poly;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_poly <= LFSR_POLY;
        end else if (load) begin
            r_poly <= poly_in;
        end
    end

    assign w_poly = r_poly;
`else
    // Port kept for interface compatibility; taps are fixed in this build.
    logic w_unused_poly;
    assign w_unused_poly = ^poly_in;
    assign w_poly        = LFSR_POLY;
`endif

    // Unroll OUT_BITS Galois steps; the first emitted bit lands in the word MSB.
    always_comb begin
        w_next = r_state;
        w_word = '0;
        for (int unsigned k = 0; k < OUT_BITS; k++) begin
            w_word = (w_word << 1) | OUT_BITS'(w_next[LFSR_WIDTH-1]);
            w_next = {w_next[LFSR_WIDTH-2:0], 1'b0} ^ (w_next[LFSR_WIDTH-1] ? w_poly : '0);
        end
    end

    // A new word is produced when the output register is empty or being drained.
    assign w_gen = enable && ((r_fsm == StEmpty) || out_ready);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fsm    <= StEmpty;
            r_state  <= LFSR_SEED;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
        end else if (load) begin
            r_fsm   <= StEmpty;
            r_valid <= 1'b0;
            if (seed_in == '0) begin
                r_state  <= LFSR_SEED;
                r_lockup <= 1'b1;
            end else begin
                r_state  <= seed_in;
                r_lockup <= 1'b0;
            end
        end else begin
            unique case (r_fsm)
                StEmpty: begin
                    if (enable) begin
                        r_fsm   <= StFull;
                        r_valid <= 1'b1;
                    end
                end
                StFull: begin
                    if (out_ready && !enable) begin
                        r_fsm   <= StEmpty;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_fsm   <= StEmpty;
                    r_valid <= 1'b0;
                end
            endcase
            if (w_gen) begin
                r_data <= w_word;
                // Degenerate taps can collapse the state to zero; reseed and flag it.
                if (w_next == '0) begin
                    r_state  <= LFSR_SEED;
                    r_lockup <= 1'b1;
                end else begin
                    r_state <= w_next;
                end
            end
        end
    end

    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign lockup_err = r_lockup;
    assign state_o    = r_state;

endmodule

// File: tb/tb_galois_lfsr_stream.sv
// Bench for galois_lfsr_stream: 1-bit and 8-bit beat instances against a polynomial-arithmetic model.
module tb_galois_lfsr_stream;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       load;
    logic       out_ready;
    logic [7:0] seed_in;
    logic [7:0] poly_in;

    logic [0:0] o1_data;
    logic       o1_valid;
    logic       o1_err;
    logic [7:0] o1_state;
    logic [7:0] o8_data;
    logic       o8_valid;
    logic       o8_err;
    logic [7:0] o8_state;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    int unsigned m_s [2];
    int unsigned m_d [2];
    int unsigned m_v [2];
    int unsigned m_e [2];
    int unsigned m_p;
    int unsigned nb  [2] = '{1, 8};

    galois_lfsr_stream #(
        .LFSR_WIDTH (8),
        .LFSR_POLY  (8'h1D),
        .LFSR_SEED  (8'h01),
        .OUT_BITS   (1)
    ) u_dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .load       (load),
        .seed_in    (seed_in),
        .poly_in    (poly_in),
        .out_data   (o1_data),
        .out_valid  (o1_valid),
        .out_ready  (out_ready),
        .lockup_err (o1_err),
        .state_o    (o1_state)
    );

    galois_lfsr_stream #(
        .LFSR_WIDTH (8),
        .LFSR_POLY  (8'h1D),
        .LFSR_SEED  (8'h01),
        .OUT_BITS   (8)
    ) u_dut8 (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .load       (load),
        .seed_in    (seed_in),
        .poly_in    (poly_in),
        .out_data   (o8_data),
        .out_valid  (o8_valid),
        .out_ready  (out_ready),
        .lockup_err (o8_err),
        .state_o    (o8_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each step multiplies the state by x modulo P(x) = x^8 + taps; the bit shifted out is emitted.
    task automatic gen(input int i);
        int unsigned s;
        int unsigned w;
        s = m_s[i];
        w = 0;
        for (int k = 0; k < nb[i]; k++) begin
            w = (w << 1) | ((s >> 7) & 1);
            s = s << 1;
            if ((s & 32'h100) != 0) s = s ^ (32'h100 | m_p);
            s = s & 32'hFF;
        end
        m_d[i] = w;
        if (s == 0) begin
            m_s[i] = 1;
            m_e[i] = 1;
        end else begin
            m_s[i] = s;
        end
    endtask

    task automatic model_step();
        if (!reset_n) begin
            m_p = 32'h1D;
        end else if (load) begin
`ifdef GALOIS_LFSR_RUNTIME_POLY_EN
            m_p = poly_in;
`endif
        end
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_s[i] = 1;
                m_d[i] = 0;
                m_v[i] = 0;
                m_e[i] = 0;
            end else if (load) begin
                m_s[i] = (seed_in == 8'h00) ? 1 : seed_in;
                m_e[i] = (seed_in == 8'h00) ? 1 : 0;
                m_v[i] = 0;
            end else if (enable && (m_v[i] == 0 || out_ready)) begin
                gen(i);
                m_v[i] = 1;
            end else if (m_v[i] != 0 && out_ready) begin
                m_v[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("d1_valid", o1_valid, m_v[0]);
        check_eq("d1_data",  o1_data,  m_d[0]);
        check_eq("d1_state", o1_state, m_s[0]);
        check_eq("d1_err",   o1_err,   m_e[0]);
        check_eq("d8_valid", o8_valid, m_v[1]);
        check_eq("d8_data",  o8_data,  m_d[1]);
        check_eq("d8_state", o8_state, m_s[1]);
        check_eq("d8_err",   o8_err,   m_e[1]);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [7:0] bits1;
        int         period;

        reset_n   = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        out_ready = 1'b0;
        seed_in   = 8'h00;
        poly_in   = 8'h00;
        tick();
        tick();
        check_eq("rst_state", o8_state, 8'h01);
        check_eq("rst_valid", o1_valid, 1'b0);
        check_eq("rst_data",  o8_data,  8'h00);
        check_eq("rst_err",   o8_err,   1'b0);

        // Free-running default stream.
        reset_n   = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        bits1     = 8'h00;
        period    = 0;
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (k <= 8) bits1 = {bits1[6:0], o1_data[0]};
            if (k == 1) begin
                check_eq("wide_beat0", o8_data, 8'h01);
                check_eq("first_valid", o8_valid, 1'b1);
            end
            if (k == 2) begin
                check_eq("wide_beat1", o8_data, 8'h1C);
                check_eq("wide_state1", o8_state, 8'h4C);
            end
            if (k == 8) begin
                check_eq("serial_8bits", bits1, 8'h01);
                check_eq("serial_state8", o1_state, 8'h1D);
            end
            if (period == 0 && o1_state == 8'h01) period = k;
        end
        check_eq("period", period, 255);

        // Backpressure with enable dropped during the stall.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        enable    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("stall_data",  o8_data,  8'h1C);
            check_eq("stall_valid", o8_valid, 1'b1);
            check_eq("stall_state", o8_state, 8'h4C);
        end
        out_ready = 1'b1;
        tick();
        check_eq("drain_valid", o8_valid, 1'b0);

        // Zero-seed load, then recovery via a non-zero load.
        load    = 1'b1;
        seed_in = 8'h00;
        tick();
        load = 1'b0;
        check_eq("zload_err",   o8_err,   1'b1);
        check_eq("zload_state", o8_state, 8'h01);
        enable = 1'b1;
        tick();
        check_eq("zload_beat", o8_data, 8'h01);
        enable  = 1'b0;
        load    = 1'b1;
        seed_in = 8'h80;
        tick();
        load = 1'b0;
        check_eq("reload_err", o1_err, 1'b0);
        enable = 1'b1;
        tick();
        check_eq("reload_beat", o1_data, 1'b1);

        // Load in the same cycle as an accepted pending beat.
        out_ready = 1'b0;
        tick();
        load      = 1'b1;
        seed_in   = 8'h5A;
        out_ready = 1'b1;
        tick();
        load   = 1'b0;
        enable = 1'b0;
        check_eq("ldrop_valid", o8_valid, 1'b0);
        check_eq("ldrop_state", o8_state, 8'h5A);

`ifdef GALOIS_LFSR_RUNTIME_POLY_EN
        load    = 1'b1;
        seed_in = 8'h80;
        poly_in = 8'h00;
        tick();
        load   = 1'b0;
        enable = 1'b1;
        tick();
        check_eq("zpoly_beat",  o1_data,  1'b1);
        check_eq("zpoly_state", o1_state, 8'h01);
        check_eq("zpoly_err",   o1_err,   1'b1);
        enable  = 1'b0;
        load    = 1'b1;
        seed_in = 8'h01;
        poly_in = 8'h1D;
        tick();
        load = 1'b0;
`endif

        // Randomized traffic; the model checks every cycle.
        for (int k = 0; k < 3000; k++) begin
            reset_n   = ($urandom_range(0, 199) != 0);
            load      = ($urandom_range(0, 19) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            poly_in   = 8'($urandom);
            enable    = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
